mfp_ahb_sevensegscan: RTL and testbench
=======================================

Name: mfp_ahb_sevensegscan

Overview:
- Time-multiplexing scanner directly upstream of the seven-segment decoder.
- Holds eight 6-bit digit codes (bit 5 = decimal point, bits 4:0 = glyph code) in shadow registers.
- Cycles through the digits, presenting one code at a time on data_out (wired to the decoder's data input) and driving the matching active-low anode.
- Inserts an all-anodes-off blanking interval between digits to prevent ghosting.
- Takes new display contents only at frame boundaries, so a multi-digit update never tears.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; legal range 2..8.
- DIGIT_CYCLES, 50000: clk cycles each digit is driven (DRIVE state); must be >= 1.
- BLANK_CYCLES, 500: clk cycles all anodes are off before each digit (BLANK state); must be >= 1.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- digits_in, in, 6*NUM_DIGITS: digit codes; digit k is at [6k+5:6k].
- digit_en_in, in, NUM_DIGITS: per-digit enable; 0 keeps that anode off for the whole slot.
- load, in, 1: single-cycle strobe that captures digits_in and digit_en_in into staging.
- load_ack, out, 1: one-cycle pulse when staged contents are committed to the shadow registers.
- frame_done, out, 1: one-cycle pulse at every frame wrap.
- anode_n, out, NUM_DIGITS: active-low digit enables.
- data_out, out, 6: code for the currently selected digit; goes to the decoder.

Behaviour:
- Reset values:
  - Outputs: anode_n all 1s, data_out 0, load_ack 0, frame_done 0.
  - Internal: state BLANK, idx 0, slot counter 0, shadow/staging digits 0, shadow/staging enables 0, pending 0.
  - Reset asserted mid-frame aborts immediately to the reset values.
- FSM states:
  - BLANK: anode_n all 1s. After BLANK_CYCLES cycles, go to DRIVE.
  - DRIVE: anode_n[idx] = ~shadow_en[idx]; all other anode bits are 1. After DIGIT_CYCLES cycles, go to BLANK with idx advanced.
- Slot counter:
  - Counts 0..(limit-1) and resets to 0 on every state change.
  - Width is ceil(log2(max(DIGIT_CYCLES, BLANK_CYCLES)+1)).
- Index:
  - idx increments on the DRIVE->BLANK edge.
  - At idx = NUM_DIGITS-1 it wraps to 0; that edge is the frame boundary.
- data_out:
  - Registered; loaded on each transition into BLANK with the shadow code of the new idx.
  - Therefore it is stable for BLANK_CYCLES before the anode asserts, and unchanged throughout DRIVE.
  - After reset, data_out = shadow digit 0 (= 0).
- Frame period: NUM_DIGITS*(BLANK_CYCLES+DIGIT_CYCLES) cycles.
- Load handshake:
  - load=1 captures digits_in/digit_en_in into staging on that edge and sets pending.
  - A further load while pending overwrites staging; only one load_ack results. The last write wins.
- Commit at frame boundary, when pending=1:
  - shadow <= staging and pending <= 0.
  - data_out <= staging digit 0, so the new frame begins with new content.
  - load_ack is 1 for the first cycle of the new frame.
- Load and frame boundary on the same edge:
  - digits_in is captured into staging and pending is set, but the commit uses the previous staging contents (or nothing, if pending was 0).
  - The new data commits at the following frame boundary.
- frame_done: 1 for the first cycle of every frame (first BLANK cycle with idx 0), including the first frame after reset exits. Never asserted during reset.
- Decimal point passes through unaltered in bit 5; the block never interprets glyph codes.
- Disabled digit: its time slot is still consumed (constant brightness), and data_out still updates.

Decomposition:
- Shared package mfp_sevenseg_pkg:
  - state enum {BLANK, DRIVE}.
  - DIGIT_W = 6, DP_BIT = 5, MAX_DIGITS = 8.
  - Default DIGIT_CYCLES/BLANK_CYCLES constants.
- One sub-module: mfp_sevenseg_slot_timer.
  - Loadable down-counter with a terminal-count pulse.
  - Reused for the BLANK and DRIVE durations.
- FSM, staging/shadow registers and handshake stay in the top.

Test Plan (bench uses NUM_DIGITS=8, DIGIT_CYCLES=4, BLANK_CYCLES=2; frame = 48 cycles):
- Reset release, digits never loaded -> anode_n=8'hFF for all cycles (enables 0); frame_done pulses at cycles 0, 48, 96; data_out=0 throughout.
- load at cycle 5 with digits k=code k (0..7), en=8'hFF -> no change until cycle 48; load_ack=1 only at cycle 48; then anode_n=8'hFE for cycles 50-53 with data_out=6'd0, and anode_n=8'hFD for cycles 56-59 with data_out=6'd1; data_out changes only in BLANK.
- Load at cycle 10 with digit 3=6'h25, then load at cycle 20 with digit 3=6'h07 -> single load_ack at cycle 48; digit 3 slot shows 6'h07.
- load asserted exactly on the frame boundary edge -> no commit at that boundary; commit and load_ack at the next boundary, 48 cycles later.
- en=8'b1010_1010 -> anode bits 0,2,4,6 never go low; slot timing unchanged; odd digits driven 4 cycles each.
- reset pulsed mid-DRIVE of digit 5 -> anode_n=8'hFF and data_out=0 asynchronously; the scan restarts at digit 0 with shadow cleared.

Source files
------------

// File: rtl/mfp_sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan path.
package mfp_sevenseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam int DIGIT_W          = 6;
    localparam int DP_BIT           = 5;
    localparam int MAX_DIGITS       = 8;
    localparam int DEF_DIGIT_CYCLES = 50000;
    localparam int DEF_BLANK_CYCLES = 500;

endpackage

// File: rtl/mfp_sevenseg_slot_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module mfp_sevenseg_slot_timer
    import mfp_sevenseg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count_r;

    // Count down from the loaded value and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mfp_ahb_sevensegscan.sv
// Seven-segment digit scanner: blank/drive time multiplexing with
// frame-boundary commit of staged display contents.
module mfp_ahb_sevensegscan
    import mfp_sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = DEF_DIGIT_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         digit_en_in,
    input  logic                          load,
    output logic                          load_ack,
    output logic                          frame_done,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [DIGIT_W-1:0]            data_out
);

    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAX_CYC   = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);
    localparam int VEC_W     = DIGIT_W * NUM_DIGITS;
    localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    scan_state_t            state_r;
    logic [IDX_W-1:0]       idx_r;
    logic                   run_r;
    logic                   pending_r;
    logic [VEC_W-1:0]       stage_digits_r;
    logic [NUM_DIGITS-1:0]  stage_en_r;
    logic [VEC_W-1:0]       shadow_digits_r;
    logic [NUM_DIGITS-1:0]  shadow_en_r;
    logic                   slot_tc_s;
    logic                   timer_load_s;
    logic [CNT_W-1:0]       timer_val_s;
    logic                   wrap_s;

    function automatic logic [DIGIT_W-1:0] digit_at(input logic [VEC_W-1:0] vec,
                                                    input logic [IDX_W-1:0] i);
        return vec[DIGIT_W*int'(i) +: DIGIT_W];
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_pattern(input logic [IDX_W-1:0] i,
                                                            input logic [NUM_DIGITS-1:0] en);
        logic [NUM_DIGITS-1:0] onehot;
        onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << i;
        return ~(onehot & en);
    endfunction

    mfp_sevenseg_slot_timer #(
        .CNT_W (CNT_W)
    ) u_slot_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .tc       (slot_tc_s)
    );

    // Reload the slot timer on every state change; the first edge out of reset starts a frame.
    always_comb begin
        timer_load_s = 1'b0;
        timer_val_s  = BLANK_LOAD;
        wrap_s       = 1'b0;
        if (!run_r) begin
            timer_load_s = 1'b1;
            timer_val_s  = BLANK_LOAD;
            wrap_s       = 1'b1;
        end else if (slot_tc_s) begin
            timer_load_s = 1'b1;
            timer_val_s  = (state_r == BLANK) ? DRIVE_LOAD : BLANK_LOAD;
            wrap_s       = (state_r == DRIVE) && (idx_r == LAST_IDX);
        end else begin
            timer_load_s = 1'b0;
            timer_val_s  = BLANK_LOAD;
            wrap_s       = 1'b0;
        end
    end

    // Scan FSM, staging/shadow registers and load handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= BLANK;
            idx_r           <= IDX_ZERO;
            run_r           <= 1'b0;
            pending_r       <= 1'b0;
            stage_digits_r  <= {VEC_W{1'b0}};
            stage_en_r      <= {NUM_DIGITS{1'b0}};
            shadow_digits_r <= {VEC_W{1'b0}};
            shadow_en_r     <= {NUM_DIGITS{1'b0}};
            anode_n         <= {NUM_DIGITS{1'b1}};
            data_out        <= {DIGIT_W{1'b0}};
            load_ack        <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
            if (load) begin
                stage_digits_r <= digits_in;
                stage_en_r     <= digit_en_in;
            end else begin
                stage_digits_r <= stage_digits_r;
                stage_en_r     <= stage_en_r;
            end

            if (wrap_s) begin
                run_r      <= 1'b1;
                state_r    <= BLANK;
                idx_r      <= IDX_ZERO;
                anode_n    <= {NUM_DIGITS{1'b1}};
                frame_done <= 1'b1;
                // A load on this same edge lands in staging and waits for the next wrap.
                if (pending_r) begin
                    shadow_digits_r <= stage_digits_r;
                    shadow_en_r     <= stage_en_r;
                    data_out        <= digit_at(stage_digits_r, IDX_ZERO);
                    load_ack        <= 1'b1;
                    pending_r       <= load;
                end else begin
                    data_out  <= digit_at(shadow_digits_r, IDX_ZERO);
                    pending_r <= load;
                end
            end else begin
                pending_r <= pending_r | load;
                if (slot_tc_s) begin
                    case (state_r)
                        BLANK: begin
                            state_r <= DRIVE;
                            anode_n <= anode_pattern(idx_r, shadow_en_r);
                        end
                        DRIVE: begin
                            state_r  <= BLANK;
                            idx_r    <= idx_r + IDX_ONE;
                            anode_n  <= {NUM_DIGITS{1'b1}};
                            data_out <= digit_at(shadow_digits_r, idx_r + IDX_ONE);
                        end
                        default: begin
                            state_r <= BLANK;
                            anode_n <= {NUM_DIGITS{1'b1}};
                        end
                    endcase
                end else begin
                    state_r <= state_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_mfp_ahb_sevensegscan.sv
// Self-checking bench for mfp_ahb_sevensegscan against a frame-position reference model.
module tb_mfp_ahb_sevensegscan;

    localparam int ND    = 8;
    localparam int DC    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = DC + BC;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          reset;
    logic [47:0]   digits_in;
    logic [7:0]    digit_en_in;
    logic          load;
    logic          load_ack;
    logic          frame_done;
    logic [7:0]    anode_n;
    logic [5:0]    data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: display contents plus the cycle number since reset exit.
    int          c;
    logic [47:0] m_shadow, m_stage;
    logic [7:0]  m_en, m_stage_en;
    bit          m_pending, m_ack;

    mfp_ahb_sevensegscan #(
        .NUM_DIGITS   (ND),
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .digit_en_in (digit_en_in),
        .load        (load),
        .load_ack    (load_ack),
        .frame_done  (frame_done),
        .anode_n     (anode_n),
        .data_out    (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] rand48();
        return {16'($urandom), $urandom};
    endfunction

    task automatic model_clear();
        m_shadow = 48'd0; m_stage = 48'd0; m_en = 8'd0; m_stage_en = 8'd0;
        m_pending = 1'b0; m_ack = 1'b0; c = -1;
    endtask

    task automatic check_reset_vals(input string tag);
        n_cmp++;
        assert (anode_n === 8'hFF) else begin n_fail++; $error("FAIL %s anode_n got %h exp ff", tag, anode_n); end
        n_cmp++;
        assert (data_out === 6'd0) else begin n_fail++; $error("FAIL %s data_out got %h exp 00", tag, data_out); end
        n_cmp++;
        assert (frame_done === 1'b0) else begin n_fail++; $error("FAIL %s frame_done got %b exp 0", tag, frame_done); end
        n_cmp++;
        assert (load_ack === 1'b0) else begin n_fail++; $error("FAIL %s load_ack got %b exp 0", tag, load_ack); end
    endtask

    // Drive one cycle's inputs, advance the model across the edge, then check all outputs.
    task automatic run_cycle(input logic ld, input logic [47:0] d, input logic [7:0] e);
        int pos, slot, w;
        logic [7:0] exp_an;
        logic [5:0] exp_data;
        load = ld; digits_in = d; digit_en_in = e;
        @(posedge clk);
        c++;
        pos = c % FRAME;
        m_ack = 1'b0;
        if (pos == 0 && m_pending) begin
            m_shadow = m_stage; m_en = m_stage_en; m_pending = 1'b0; m_ack = 1'b1;
        end
        if (ld) begin
            m_stage = d; m_stage_en = e; m_pending = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        slot = pos / SLOT;
        w    = pos % SLOT;
        exp_an   = (w < BC) ? 8'hFF : ~((8'd1 << slot) & m_en);
        exp_data = m_shadow[slot*6 +: 6];
        n_cmp++;
        assert (anode_n === exp_an) else begin n_fail++; $error("FAIL anode_n c=%0d got %h exp %h", c, anode_n, exp_an); end
        n_cmp++;
        assert (data_out === exp_data) else begin n_fail++; $error("FAIL data_out c=%0d got %h exp %h", c, data_out, exp_data); end
        n_cmp++;
        assert (frame_done === (pos == 0)) else begin n_fail++; $error("FAIL frame_done c=%0d got %b exp %b", c, frame_done, pos == 0); end
        n_cmp++;
        assert (load_ack === m_ack) else begin n_fail++; $error("FAIL load_ack c=%0d got %b exp %b", c, load_ack, m_ack); end
    endtask

    task automatic idle();
        run_cycle(1'b0, rand48(), 8'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("in_reset");
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [47:0] v;
        reset = 1'b1; load = 1'b0; digits_in = 48'd0; digit_en_in = 8'd0;
        model_clear();
        repeat (2) @(negedge clk);

        // Never loaded: all anodes off, frame_done every 48 cycles.
        do_reset();
        while (c < 100) idle();

        // Load digit k = k with all enables at cycle 5; commit at 48.
        do_reset();
        while (c < 5) idle();
        for (int k = 0; k < ND; k++) v[k*6 +: 6] = 6'(k);
        run_cycle(1'b1, v, 8'hFF);
        while (c < 100) idle();

        // Two loads in one frame: last write wins, single ack.
        v = rand48(); v[23:18] = 6'h25;
        run_cycle(1'b1, v, 8'hFF);
        while (c < 110) idle();
        v = rand48(); v[23:18] = 6'h07;
        run_cycle(1'b1, v, 8'hFF);
        while (c < 150) idle();

        // Load on the boundary edge: deferred by one frame.
        while (c < 191) idle();
        run_cycle(1'b1, rand48(), 8'($urandom));
        while (c < 250) idle();

        // Alternate enables: even anodes never asserted.
        run_cycle(1'b1, rand48(), 8'b1010_1010);
        while (c < 400) idle();

        // Random loads at random times.
        repeat (300) run_cycle(($urandom_range(0, 19) == 0), rand48(), 8'($urandom));

        // Asynchronous reset in the middle of digit 5's drive slot.
        run_cycle(1'b1, rand48(), 8'hFF);
        repeat (100) idle();
        while ((c % FRAME) != (5 * SLOT + BC + 1)) idle();
        #2 reset = 1'b1;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (60) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
